// File: rtl/hs4_sync_pkg.sv
// hs4_sync_pkg: shared types and constants for the 4-phase req/ack bus
// synchronizer (destination side and its bit synchronizer).
//   hs4_state_e     : destination FSM states (IDLE, HOLD, ACK), 2-bit.
//   HS4_SYNC_STAGES : flop count of the single-bit synchronizer.
//   hs4_cnt_width() : width of the ACK-state timeout counter.
package hs4_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } hs4_state_e;

  localparam int unsigned HS4_SYNC_STAGES = 2;

  // Counter must hold 0 .. cycles-1.
  function automatic int unsigned hs4_cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/hs_bit_sync.sv
// hs_bit_sync: multi-flop single-bit synchronizer (HS4_SYNC_STAGES flops),
// asynchronous active-low reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input level
//   q     : synchronized level
module hs_bit_sync
  import hs4_sync_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [HS4_SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[HS4_SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[HS4_SYNC_STAGES-1];

endmodule

// File: rtl/hs4_sync_dest.sv
// hs4_sync_dest: destination half of a 4-phase req/ack bus synchronizer.
// Synchronizes src_req into clk_dest, captures the source-held src_data and
// offers it on a valid/ready interface, then returns a registered ack level.
//   clk_dest    : destination clock
//   rst_dest_n  : asynchronous active-low reset
//   src_req     : asynchronous request level from the source domain
//   src_data    : source data, stable from src_req rise until dest_ack high
//   dest_valid  : captured word available
//   dest_ready  : consumer accepts the word
//   dest_data   : captured word (changes only on capture)
//   dest_ack    : ack level back to the source domain (registered)
//   dest_busy   : high whenever the FSM is not IDLE
//   dest_err    : sticky ACK timeout flag
// Optional feature: define HS4_TIMEOUT_EN to bound the ACK wait to
// TIMEOUT_CYCLES clk_dest cycles; otherwise dest_err is tied 0.
module hs4_sync_dest
  import hs4_sync_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_dest,
  input  logic              rst_dest_n,
  input  logic              src_req,
  input  logic [DATA_W-1:0] src_data,
  output logic              dest_valid,
  input  logic              dest_ready,
  output logic [DATA_W-1:0] dest_data,
  output logic              dest_ack,
  output logic              dest_busy,
  output logic              dest_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("hs4_sync_dest: TIMEOUT_CYCLES must be >= 2");
  end

  logic                       req_s;
  hs4_state_e                 state;
  logic                       armed;
  logic [HS4_SYNC_STAGES-1:0] warm;

  hs_bit_sync u_req_sync (
    .clk   (clk_dest),
    .rst_n (rst_dest_n),
    .d     (src_req),
    .q     (req_s)
  );

`ifdef HS4_TIMEOUT_EN
  localparam int unsigned     CNT_W   = hs4_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] ack_cnt;
  logic             err_q;

  assign dest_err = err_q;
`else
  assign dest_err = 1'b0;
`endif

  always_ff @(posedge clk_dest or negedge rst_dest_n) begin
    if (!rst_dest_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      warm       <= '0;
      dest_valid <= 1'b0;
      dest_data  <= '0;
      dest_ack   <= 1'b0;
      dest_busy  <= 1'b0;
`ifdef HS4_TIMEOUT_EN
      ack_cnt    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      // The synchronizer flops reset to 0, so req_s reads low until they have
      // refilled from src_req; arming waits for that so a request held high
      // across reset is not mistaken for a fresh one.
      warm <= {warm[HS4_SYNC_STAGES-2:0], 1'b1};
      if (warm[HS4_SYNC_STAGES-1] && !req_s) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (armed && req_s) begin
            dest_data  <= src_data;
            dest_valid <= 1'b1;
            dest_busy  <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          // dest_valid is always high here; a req_s drop is ignored.
          if (dest_ready) begin
            dest_valid <= 1'b0;
            dest_ack   <= 1'b1;
            state      <= ACK;
`ifdef HS4_TIMEOUT_EN
            ack_cnt    <= '0;
`endif
          end
        end
        ACK: begin
          if (!req_s) begin
            dest_ack  <= 1'b0;
            dest_busy <= 1'b0;
            state     <= IDLE;
          end
`ifdef HS4_TIMEOUT_EN
          else if (ack_cnt == CNT_MAX) begin
            err_q     <= 1'b1;
            dest_ack  <= 1'b0;
            dest_busy <= 1'b0;
            armed     <= 1'b0;
            state     <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
`endif
        end
        default: begin
          dest_valid <= 1'b0;
          dest_ack   <= 1'b0;
          dest_busy  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hs4_sync_dest.md
Name: hs4_sync_dest

Overview:
- Destination-side half of a 4-phase req/ack bus synchronizer.
- Consumes an asynchronous request level plus a source-held data bus, synchronizes the request into clk_dest, captures the data, and presents it on a valid/ready interface.
- Returns an ack level to the source domain; the source side re-synchronizes the ack.
- Used for crossing low-rate control/config words into the controller clock domain.

Parameters:
- DATA_W, 32, width of src_data / dest_data.
- TIMEOUT_CYCLES, 1024, ACK-state wait limit in clk_dest cycles (used only with the optional feature); must be >= 2.

Ports:
- clk_dest  in  1  destination clock.
- rst_dest_n  in  1  asynchronous, active-low reset, clk_dest domain.
- src_req  in  1  asynchronous request level from the source domain.
- src_data  in  DATA_W  source data; stable from src_req rise until dest_ack is seen high.
- dest_valid  out  1  captured word available.
- dest_ready  in  1  consumer accepts the word.
- dest_data  out  DATA_W  captured word, registered.
- dest_ack  out  1  ack level to the source domain, registered, glitch-free.
- dest_busy  out  1  high whenever state != IDLE.
- dest_err  out  1  sticky timeout flag; tied 0 unless HS4_TIMEOUT_EN is defined.

Behaviour:
- src_req passes through 2 flops (reset value 0) to give req_s. Latency is 2 clk_dest edges from a stable src_req to req_s.
- Reset values: dest_valid=0, dest_data=0, dest_ack=0, dest_busy=0, dest_err=0, state=IDLE, armed=0.
- armed flag:
  - Set on the first cycle req_s=0 after reset.
  - Prevents capture if src_req is already high when reset releases. A request that was in flight across reset is dropped until the source lowers req.
- FSM states: IDLE, HOLD, ACK.
  - IDLE: if armed and req_s=1, then at the next edge dest_data<=src_data, dest_valid<=1, go to HOLD. Capture occurs 3 edges after the src_req rise, worst case plus sync uncertainty.
  - HOLD: dest_valid=1 and dest_data stable. When dest_valid&dest_ready, then at the next edge dest_valid<=0, dest_ack<=1, go to ACK. dest_ready arriving in the same cycle valid first rises counts as a transfer. A req_s drop while in HOLD is a protocol violation and is ignored; the word is still delivered.
  - ACK: dest_ack=1. When req_s=0, then at the next edge dest_ack<=0, go to IDLE.
- Re-arm: a new req_s=1 in IDLE is accepted immediately. Back-to-back transfers therefore need no idle bubble beyond the sync latency.
- Simultaneous events:
  - req_s=0 arriving in ACK while TIMEOUT fires: the normal exit wins and dest_err is not set.
  - Reset overrides everything, any state, asynchronously.
- dest_data changes only on capture; it holds its value through ACK and IDLE.

Optional Feature:
- Macro: HS4_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACK and increments each ACK cycle.
  - If it reaches TIMEOUT_CYCLES-1 with req_s still 1: set dest_err (sticky until reset), drop dest_ack, and go to IDLE with armed=0. armed re-arms once req_s is seen low.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter logic; dest_err tied 0; ACK waits indefinitely.

Decomposition:
- Package hs4_sync_pkg holds:
  - state enum hs4_state_e {IDLE, HOLD, ACK} (2-bit).
  - constant HS4_SYNC_STAGES=2.
  - function for timeout counter width.
- One sub-module: hs_bit_sync, a 2-flop single-bit synchronizer with async active-low reset to 0. It is instantiated for src_req.
- The matching source-side block (separate spec) reuses hs_bit_sync for dest_ack.

Test Plan:
- Basic transfer: src_data=32'hDEADBEEF, src_req 0→1, dest_ready=1 → dest_valid high for 1 cycle within 3 edges, dest_data=DEADBEEF, dest_ack=1 next edge. Drop src_req → dest_ack=0 within 3 edges, dest_busy=0.
- Backpressure: dest_ready=0 for 10 cycles after valid → dest_valid and dest_data=32'h12345678 held, dest_ack stays 0. Raise ready → ack rises the following edge.
- Reset with req high: src_req=1 across rst_dest_n release → no dest_valid. Then src_req 1→0→1 with data 32'hA5A5A5A5 → exactly one capture of A5A5A5A5.
- Back-to-back: 4 handshakes with data 1,2,3,4 driven by a source-side BFM with random clk ratio (0.3x–3x) → exactly 4 valid beats, in order, no duplicates.
- Mid-operation reset: assert rst_dest_n in HOLD and again in ACK → all outputs 0 asynchronously; the next full handshake completes normally.
- Timeout (HS4_TIMEOUT_EN, TIMEOUT_CYCLES=16): hold src_req high after ack → dest_err=1 at the 16th ACK cycle, dest_ack=0, no new capture until src_req toggles low→high. Without the macro, dest_err stays 0 and ack is held.
